// File: rtl/zone_pkg.sv
// zone_pkg: shared defaults, FSM state type and byte-index width helper for zone_spi_tx
package zone_pkg;
   localparam int         ZONES_DFLT  = 360;
   localparam logic [7:0] HEADER_BYTE = 8'hA5;
   typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_e;
   function automatic int idx_width(input int zones);
      return $clog2(zones + 1);
   endfunction
   localparam int IDX_W_DFLT = idx_width(ZONES_DFLT);
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 MSB-first byte serializer with SCLK divider and bit counter
module spi_byte_shifter #(
   parameter int SCLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       stop_i,
   input  logic [7:0] byte_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       byte_done_o
);
   localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   logic [7:0]    sr_q, sr_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic          sclk_q, sclk_d, act_q, act_d;
   logic          tick, fall;
   assign tick        = act_q && (div_q == DW'(SCLK_DIV - 1));
   assign fall        = tick && sclk_q;
   assign byte_done_o = fall && (bit_q == 3'd0);
   assign sclk_o      = sclk_q;
   assign mosi_o      = sr_q[7];
   // A load lands on the falling edge that ends bit 0, so MOSI only moves with SCLK falling
   always_comb begin
      sr_d   = fall ? {sr_q[6:0], 1'b0} : sr_q;
      bit_d  = fall ? bit_q - 3'd1 : bit_q;
      sclk_d = tick ? ~sclk_q : sclk_q;
      div_d  = act_q ? (tick ? '0 : div_q + DW'(1)) : '0;
      act_d  = act_q;
      if (load_i) begin
         sr_d   = byte_i;
         bit_d  = 3'd7;
         sclk_d = 1'b0;
         div_d  = '0;
         act_d  = 1'b1;
      end else if (stop_i) begin
         sclk_d = 1'b0;
         div_d  = '0;
         act_d  = 1'b0;
      end
   end
   // Shifter state register
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q   <= '0;
         bit_q  <= '0;
         sclk_q <= 1'b0;
         div_q  <= '0;
         act_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         bit_q  <= bit_d;
         sclk_q <= sclk_d;
         div_q  <= div_d;
         act_q  <= act_d;
      end
   end
endmodule

// File: rtl/zone_spi_tx.sv
// zone_spi_tx: snapshots the zone buffer per frame and streams header+zones over SPI; ZONE_IIR_EN adds per-zone temporal smoothing
module zone_spi_tx
   import zone_pkg::*;
#(
   parameter int         ZONES      = ZONES_DFLT,
   parameter int         SCLK_DIV   = 4,
   parameter int         GAP_CYCLES = 16,
   parameter logic [7:0] HEADER     = HEADER_BYTE
) (
   input  logic               i_pix_clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic [ZONES*8-1:0] buf_360_flatted,
   output logic               spi_sclk,
   output logic               spi_mosi,
   output logic               spi_cs_n,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);
   localparam int IW      = idx_width(ZONES);
   localparam int CNT_MAX = (GAP_CYCLES > SCLK_DIV) ? GAP_CYCLES : SCLK_DIV;
   localparam int CW      = $clog2(CNT_MAX + 1);
   state_e             state_q, state_d;
   logic [ZONES*8-1:0] snap_q, snap_d;
   logic [IW-1:0]      idx_q, idx_d, zsel;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d, ovr_q, ovr_d;
   logic               load, stop, byte_done;
   logic [7:0]         x_byte, z_byte, ld_byte;
   assign zsel       = (idx_q < IW'(ZONES)) ? idx_q : '0;
   assign x_byte     = snap_q[int'(zsel)*8 +: 8];
   assign spi_cs_n   = ~((state_q == SHIFT) || (state_q == TAIL));
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign overrun    = ovr_q;
`ifdef ZONE_IIR_EN
   logic [7:0] prev_q [ZONES];
   logic [9:0] acc;
   assign acc    = 10'(prev_q[zsel]) * 10'd3 + 10'(x_byte) + 10'd2;
   assign z_byte = acc[9:2];
   // Filtered value is written back as the zone byte is handed to the shifter
   always_ff @(posedge i_pix_clk) begin
      if (rst) begin
         for (int i = 0; i < ZONES; i++) prev_q[i] <= '0;
      end else if (load && state_q == SHIFT) begin
         prev_q[zsel] <= z_byte;
      end
   end
`else
   assign z_byte = x_byte;
`endif
   // Frame sequencing: accept, walk header then zones, hold tail, enforce gap
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovr_d   = frame_start && (state_q != IDLE);
      load    = 1'b0;
      stop    = 1'b0;
      ld_byte = z_byte;
      case (state_q)
         IDLE: if (frame_start) begin
            state_d = SHIFT;
            snap_d  = buf_360_flatted;
            idx_d   = '0;
            load    = 1'b1;
            ld_byte = HEADER;
         end
         SHIFT: if (byte_done) begin
            if (idx_q == IW'(ZONES)) begin
               stop    = 1'b1;
               state_d = TAIL;
               cnt_d   = '0;
            end else begin
               load  = 1'b1;
               idx_d = idx_q + IW'(1);
            end
         end
         TAIL: if (cnt_q == CW'(SCLK_DIV - 1)) begin
            state_d = GAP;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   // Control and snapshot registers
   always_ff @(posedge i_pix_clk) begin
      if (rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end
   spi_byte_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
      .clk        (i_pix_clk),
      .rst        (rst),
      .load_i     (load),
      .stop_i     (stop),
      .byte_i     (ld_byte),
      .sclk_o     (spi_sclk),
      .mosi_o     (spi_mosi),
      .byte_done_o(byte_done)
   );
endmodule
